// File: rtl/bnn_sample_driver_if.sv
// bnn_sample_driver_if: sample, core and result signals of the BNN sample driver.
interface bnn_sample_driver_if #(
    parameter int FEAT_CNT  = 19,
    parameter int FEAT_BITS = 4,
    parameter int CLASS_CNT = 3,
    parameter int TAG_BITS  = 8
);
    localparam int PRED_BITS = $clog2(CLASS_CNT);
    logic                          in_valid;
    logic                          in_ready;
    logic [FEAT_BITS*FEAT_CNT-1:0] in_sample;
    logic [FEAT_BITS*FEAT_CNT-1:0] core_features;
    logic                          core_rst;
    logic [PRED_BITS-1:0]          core_prediction;
    logic                          out_valid;
    logic                          out_ready;
    logic [PRED_BITS-1:0]          out_class;
    logic                          out_err;
    logic [TAG_BITS-1:0]           out_tag;
    logic [31:0]                   stat_done;
    logic [31:0]                   stat_stall;
    modport master (
        input  in_valid, in_sample, core_prediction, out_ready,
        output in_ready, core_features, core_rst, out_valid, out_class, out_err, out_tag,
               stat_done, stat_stall
    );
    modport slave (
        output in_valid, in_sample, core_prediction, out_ready,
        input  in_ready, core_features, core_rst, out_valid, out_class, out_err, out_tag,
               stat_done, stat_stall
    );
endinterface

// File: rtl/bnn_sample_driver.sv
// bnn_sample_driver: feeds one sample to a bit-serial BNN core, times its run, returns the class.
// Optional BNN_DRV_STATS_EN adds result/stall counters; otherwise the stat outputs are tied to 0.
module bnn_sample_driver #(
    parameter int FEAT_CNT   = 19,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 3,
    parameter int LATENCY    = FEAT_CNT + HIDDEN_CNT,
    parameter int TAG_BITS   = 8
) (
    input logic clk,
    input logic rst,
    bnn_sample_driver_if.master bus
);
    localparam int PRED_BITS = $clog2(CLASS_CNT);
    localparam int CNT_BITS  = $clog2(LATENCY + 1);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LATENCY - 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t                        r_state;
    logic [CNT_BITS-1:0]           r_cnt;
    logic [TAG_BITS-1:0]           r_seq;
    logic [TAG_BITS-1:0]           r_tag;
    logic [FEAT_BITS*FEAT_CNT-1:0] r_feat;
    logic [PRED_BITS-1:0]          r_class;
    logic                          r_err;
    logic                          r_in_ready;
    logic                          r_core_rst;
    logic                          r_out_valid;
    logic                          w_err;
    logic [PRED_BITS-1:0]          w_class;
    // Classes are reported in reverse order of the core's encoding; out-of-range codes flag an error.
    assign w_err   = 32'(bus.core_prediction) >= CLASS_CNT;
    assign w_class = w_err ? '0 : PRED_BITS'(CLASS_CNT - 1) - bus.core_prediction;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_seq       <= '0;
            r_tag       <= '0;
            r_feat      <= '0;
            r_class     <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_core_rst  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_feat     <= bus.in_sample;
                    r_in_ready <= 1'b0;
                    r_state    <= LOAD;
                end
                LOAD: begin
                    r_cnt      <= '0;
                    r_core_rst <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: if (r_cnt == LAST) begin
                    r_class     <= w_class;
                    r_err       <= w_err;
                    r_tag       <= r_seq;
                    r_core_rst  <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    r_seq       <= r_seq + 1'b1;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    assign bus.in_ready      = r_in_ready;
    assign bus.core_features = r_feat;
    assign bus.core_rst      = r_core_rst;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_class     = r_class;
    assign bus.out_err       = r_err;
    assign bus.out_tag       = r_tag;
`ifdef BNN_DRV_STATS_EN
    logic [31:0] r_stat_done;
    logic [31:0] r_stat_stall;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_stat_done  <= '0;
            r_stat_stall <= '0;
        end else if (r_state == DONE) begin
            if (bus.out_ready) r_stat_done <= r_stat_done + 1'b1;
            else r_stat_stall <= r_stat_stall + 1'b1;
        end
    assign bus.stat_done  = r_stat_done;
    assign bus.stat_stall = r_stat_stall;
`else
    assign bus.stat_done  = '0;
    assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_bnn_sample_driver.sv
// tb_bnn_sample_driver: directed checks of the sample driver with stub cores (default and TAG_BITS=2/LATENCY=1).
module tb_bnn_sample_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bnn_sample_driver_if #(.FEAT_CNT(19), .FEAT_BITS(4), .CLASS_CNT(3), .TAG_BITS(8)) a_if ();
    bnn_sample_driver #(.FEAT_CNT(19), .FEAT_BITS(4), .HIDDEN_CNT(40), .CLASS_CNT(3), .TAG_BITS(8))
        dut_a (.clk(clk), .rst(rst), .bus(a_if));

    bnn_sample_driver_if #(.FEAT_CNT(2), .FEAT_BITS(4), .CLASS_CNT(3), .TAG_BITS(2)) b_if ();
    bnn_sample_driver #(.FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(0), .CLASS_CNT(3), .LATENCY(1), .TAG_BITS(2))
        dut_b (.clk(clk), .rst(rst), .bus(b_if));

    // Stub core: the real prediction only appears once 59 run cycles have elapsed.
    logic [1:0] a_pred = 2'd0;
    int         a_run = 0;
    always @(posedge clk) a_run <= a_if.core_rst ? 0 : a_run + 1;
    assign a_if.core_prediction = (a_run >= 58) ? a_pred : a_pred ^ 2'd1;
    assign b_if.core_prediction = 2'd1;

`ifdef BNN_DRV_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_a_valid(output int k);
        k = 0;
        while (!a_if.out_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq("a_valid_timeout", a_if.out_valid, 1);
    endtask

    task automatic run_a(input string tag, input logic [1:0] p, input logic [1:0] ec,
                         input logic ee, input logic [7:0] et);
        int k;
        @(negedge clk);
        a_pred = p;
        a_if.in_sample = {19{4'(p)}};
        a_if.in_valid = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        wait_a_valid(k);
        check_eq({tag, "_class"}, a_if.out_class, ec);
        check_eq({tag, "_err"}, a_if.out_err, ee);
        check_eq({tag, "_tag"}, a_if.out_tag, et);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b0;
    endtask

    localparam logic [75:0] SAMPLE = 76'h4000d18100621208964;
    localparam logic [75:0] OTHER  = 76'h123456789abcdef0123;

    initial begin
        int k, low, cnt;
        int t[5];
        logic [7:0] tg[5];
        a_if.in_valid = 1'b0;
        a_if.in_sample = '0;
        a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0;
        b_if.in_sample = '0;
        b_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", a_if.in_ready, 1);
        check_eq("rst_core_rst", a_if.core_rst, 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", a_if.in_ready, 1);
        check_eq("idle_core_rst", a_if.core_rst, 1);
        check_eq("idle_features", a_if.core_features, 0);
        check_eq("idle_out_valid", a_if.out_valid, 0);
        check_eq("idle_tag", a_if.out_tag, 0);
        check_eq("idle_stat_done", a_if.stat_done, 0);

        // Single sample with latency and reset-window measurement
        a_pred = 2'd2;
        a_if.in_sample = SAMPLE;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        check_eq("load_features", a_if.core_features, SAMPLE);
        check_eq("load_in_ready", a_if.in_ready, 0);
        check_eq("load_core_rst", a_if.core_rst, 1);
        k = 0;
        low = 0;
        while (!a_if.out_valid && k < 300) begin
            @(negedge clk);
            k++;
            if (!a_if.core_rst) low++;
        end
        check_eq("single_latency", k, 60);
        check_eq("single_rst_low", low, 59);
        check_eq("single_class", a_if.out_class, 0);
        check_eq("single_err", a_if.out_err, 0);
        check_eq("single_tag", a_if.out_tag, 0);

        // Backpressure: offered samples must be ignored while DONE holds
        a_if.in_sample = OTHER;
        a_if.in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("bp_valid", a_if.out_valid, 1);
        check_eq("bp_class", a_if.out_class, 0);
        check_eq("bp_tag", a_if.out_tag, 0);
        check_eq("bp_in_ready", a_if.in_ready, 0);
        check_eq("bp_features", a_if.core_features, SAMPLE);
        check_eq("bp_stall", a_if.stat_stall, STATS ? 10 : 0);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b0;
        check_eq("hs_out_valid", a_if.out_valid, 0);
        check_eq("hs_in_ready", a_if.in_ready, 1);
        check_eq("hs_features", a_if.core_features, SAMPLE);
        check_eq("hs_stat_done", a_if.stat_done, STATS ? 1 : 0);
        check_eq("hs_stall_held", a_if.stat_stall, STATS ? 10 : 0);

        // Mapping and error flag
        run_a("map0", 2'd0, 2'd2, 1'b0, 8'd1);
        run_a("map1", 2'd1, 2'd1, 1'b0, 8'd2);
        run_a("map3", 2'd3, 2'd0, 1'b1, 8'd3);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a_pred = 2'd1;
        a_if.in_sample = OTHER;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("run_core_rst", a_if.core_rst, 0);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_core_rst", a_if.core_rst, 1);
        check_eq("arst_in_ready", a_if.in_ready, 1);
        check_eq("arst_features", a_if.core_features, 0);
        check_eq("arst_out_valid", a_if.out_valid, 0);
        check_eq("arst_stat_done", a_if.stat_done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_a("after_rst", 2'd2, 2'd0, 1'b0, 8'd0);

        // Back-to-back stream from a clean reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_pred = 2'd1;
        a_if.in_sample = SAMPLE;
        a_if.in_valid = 1'b1;
        a_if.out_ready = 1'b1;
        cnt = 0;
        k = 0;
        while (cnt < 5 && k < 500) begin
            @(negedge clk);
            k++;
            if (a_if.out_valid) begin
                t[cnt] = cyc;
                tg[cnt] = a_if.out_tag;
                cnt++;
            end
        end
        a_if.in_valid = 1'b0;
        check_eq("b2b_count", cnt, 5);
        for (int i = 0; i < cnt; i++) begin
            check_eq($sformatf("b2b_tag%0d", i), tg[i], i);
            if (i > 0) check_eq($sformatf("b2b_gap%0d", i), t[i] - t[i-1], 62);
        end
        @(negedge clk);
        a_if.out_ready = 1'b0;
        check_eq("b2b_stat_done", a_if.stat_done, STATS ? 5 : 0);
        check_eq("b2b_stat_stall", a_if.stat_stall, 0);

        // Narrow tag wraps; LATENCY=1 gives a 4-cycle sample period
        b_if.in_sample = 8'hA5;
        b_if.in_valid = 1'b1;
        b_if.out_ready = 1'b1;
        cnt = 0;
        k = 0;
        while (cnt < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (b_if.out_valid) begin
                t[cnt] = cyc;
                tg[cnt] = 8'(b_if.out_tag);
                check_eq($sformatf("wrap_class%0d", cnt), b_if.out_class, 1);
                cnt++;
            end
        end
        b_if.in_valid = 1'b0;
        check_eq("wrap_count", cnt, 5);
        check_eq("wrap_features", b_if.core_features, 8'hA5);
        for (int i = 0; i < cnt; i++) begin
            check_eq($sformatf("wrap_tag%0d", i), tg[i], i % 4);
            if (i > 0) check_eq($sformatf("wrap_gap%0d", i), t[i] - t[i-1], 4);
        end
        @(negedge clk);
        b_if.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
